mc_seq: RTL and testbench

MC_SEQ -- requirements
Module: mc_seq

---
 rtl/mc_pkg.sv | 55 +++++
 rtl/mc_decode.sv | 26 ++
 rtl/mc_seq.sv | 172 +++++++++++++++++
 tb/tb_mc_seq.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle sequencer: state encoding,
// opcode constants, PC source selects and the decoded-opcode class.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JAL    = 2'b10;
  localparam logic [1:0] PC_JALR   = 2'b11;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [6:0] F7_SUB     = 7'b0100000;

  // One-hot instruction class; all zero means the opcode is not recognised
  typedef struct packed {
    logic r_type;
    logic i_cal;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
  } op_class_t;

  // PC source used when an instruction retires through write-back
  function automatic logic [1:0] wb_pc_sel(input op_class_t cls);
    logic [1:0] sel;
    sel = PC_PLUS4;
    if (cls.jal) begin
      sel = PC_JAL;
    end else if (cls.jalr) begin
      sel = PC_JALR;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode classifier: one-hot class flags plus an illegal flag.
module mc_decode
  import mc_pkg::*;
(
  input  logic [6:0] operation,
  output op_class_t  op_class,
  output logic       illegal
);

  // Map the opcode onto exactly one class flag, or flag it as illegal
  always_comb begin
    op_class = '0;
    illegal  = 1'b0;
    case (operation)
      OP_R:      op_class.r_type = 1'b1;
      OP_I:      op_class.i_cal  = 1'b1;
      OP_LOAD:   op_class.load   = 1'b1;
      OP_STORE:  op_class.store  = 1'b1;
      OP_BRANCH: op_class.branch = 1'b1;
      OP_JAL:    op_class.jal    = 1'b1;
      OP_JALR:   op_class.jalr   = 1'b1;
      default:   illegal         = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_seq.sv
// Multicycle instruction sequencer: walks each instruction through
// fetch, decode, execute, memory and write-back, drives the datapath
// strobes, halts on an illegal opcode and counts retired instructions.
module mc_seq
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       operation,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             br_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_instr,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic             alu_sub,
  output logic             alu_sra,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  state_t           state;
  op_class_t        op_class;
  logic             illegal;
  logic             mem_req_q;
  logic             mem_instr_q;
  logic             mem_we_q;
  logic             rf_we_q;
  logic             pc_we_q;
  logic [1:0]       pc_sel_q;
  logic             alu_sub_q;
  logic             alu_sra_q;
  logic             halted_q;
  logic [CNT_W-1:0] instret_q;
  logic             mem_done;

  mc_decode u_decode (
    .operation (operation),
    .op_class  (op_class),
    .illegal   (illegal)
  );

  assign mem_done = mem_req_q & mem_ready;

  // Advance the sequencer and register the outputs belonging to the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RST;
      mem_req_q   <= 1'b0;
      mem_instr_q <= 1'b0;
      mem_we_q    <= 1'b0;
      rf_we_q     <= 1'b0;
      pc_we_q     <= 1'b0;
      pc_sel_q    <= PC_PLUS4;
      alu_sub_q   <= 1'b0;
      alu_sra_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      rf_we_q   <= 1'b0;
      pc_we_q   <= 1'b0;
      pc_sel_q  <= PC_PLUS4;
      alu_sub_q <= 1'b0;
      alu_sra_q <= 1'b0;
      case (state)
        ST_RST: begin
          state       <= ST_FETCH;
          mem_req_q   <= 1'b1;
          mem_instr_q <= 1'b1;
          mem_we_q    <= 1'b0;
        end
        ST_FETCH: begin
          if (mem_ready) begin
            state       <= ST_DECODE;
            mem_req_q   <= 1'b0;
            mem_instr_q <= 1'b0;
          end
        end
        ST_DECODE: begin
          if (illegal) begin
            state    <= ST_HALT;
            halted_q <= 1'b1;
          end else begin
            state     <= ST_EXEC;
            alu_sub_q <= op_class.r_type && (funct3 == F3_ADD_SUB) && (funct7 == F7_SUB);
            alu_sra_q <= (op_class.r_type || op_class.i_cal) && (funct3 == F3_SRL_SRA) && funct7[5];
            pc_we_q   <= op_class.branch;
          end
        end
        ST_EXEC: begin
          if (op_class.branch) begin
            state       <= ST_FETCH;
            mem_req_q   <= 1'b1;
            mem_instr_q <= 1'b1;
          end else if (op_class.load || op_class.store) begin
            state       <= ST_MEM;
            mem_req_q   <= 1'b1;
            mem_instr_q <= 1'b0;
            mem_we_q    <= op_class.store;
          end else begin
            state    <= ST_WB;
            rf_we_q  <= 1'b1;
            pc_we_q  <= 1'b1;
            pc_sel_q <= wb_pc_sel(op_class);
          end
        end
        ST_MEM: begin
          if (mem_ready) begin
            mem_we_q <= 1'b0;
            if (op_class.store) begin
              state       <= ST_FETCH;
              mem_req_q   <= 1'b1;
              mem_instr_q <= 1'b1;
            end else begin
              state     <= ST_WB;
              mem_req_q <= 1'b0;
              rf_we_q   <= 1'b1;
              pc_we_q   <= 1'b1;
              pc_sel_q  <= PC_PLUS4;
            end
          end
        end
        ST_WB: begin
          state       <= ST_FETCH;
          mem_req_q   <= 1'b1;
          mem_instr_q <= 1'b1;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_RST;
        end
      endcase
    end
  end

  // Strobes that must react to memory completion or the branch result within the same cycle
  always_comb begin
    ir_we  = mem_done & mem_instr_q;
    pc_we  = pc_we_q | (mem_done & mem_we_q);
    pc_sel = pc_sel_q;
    if ((state == ST_EXEC) && op_class.branch) begin
      pc_sel = br_taken ? PC_BRANCH : PC_PLUS4;
    end
  end

  // Count every cycle in which the PC is updated, wrapping naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (pc_we) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_instr = mem_instr_q;
  assign mem_we    = mem_we_q;
  assign rf_we     = rf_we_q;
  assign alu_sub   = alu_sub_q;
  assign alu_sra   = alu_sra_q;
  assign halted    = halted_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_mc_seq.sv
// Self-checking bench for mc_seq: directed and randomized instructions are
// checked against a per-instruction reference model of latency, PC select,
// strobe counts and the retired-instruction counter.
module tb_mc_seq;

  localparam int CNT_W   = 4;
  localparam int RET_MOD = 1 << CNT_W;
  localparam int TIMEOUT = 60;

  localparam int K_R     = 0;
  localparam int K_I     = 1;
  localparam int K_LOAD  = 2;
  localparam int K_STORE = 3;
  localparam int K_BR    = 4;
  localparam int K_JAL   = 5;
  localparam int K_JALR  = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [6:0]       operation;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             br_taken;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_instr;
  logic             mem_we;
  logic             ir_we;
  logic             pc_we;
  logic [1:0]       pc_sel;
  logic             rf_we;
  logic             alu_sub;
  logic             alu_sra;
  logic             halted;
  logic [CNT_W-1:0] instret;

  int checks = 0;
  int errors = 0;
  int expRet = 0;

  mc_seq #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .operation (operation),
    .funct3    (funct3),
    .funct7    (funct7),
    .br_taken  (br_taken),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_instr (mem_instr),
    .mem_we    (mem_we),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .rf_we     (rf_we),
    .alu_sub   (alu_sub),
    .alu_sra   (alu_sra),
    .halted    (halted),
    .instret   (instret)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  function automatic logic [6:0] opcodeOf(input int kind);
    case (kind)
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_LOAD:  return 7'b0000011;
      K_STORE: return 7'b0100011;
      K_BR:    return 7'b1100011;
      K_JAL:   return 7'b1101111;
      default: return 7'b1100111;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic releaseReset();
    mem_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("rst cycle mem_req", mem_req, 0);
    checkOutput("rst cycle ir_we", ir_we, 0);
    checkOutput("rst cycle pc_we", pc_we, 0);
    checkOutput("rst cycle rf_we", rf_we, 0);
    checkOutput("rst cycle halted", halted, 0);
    checkOutput("rst cycle instret", instret, 0);
    expRet = 0;
  endtask

  task automatic resetDut();
    rst_n     = 1'b0;
    operation = 7'd0;
    funct3    = 3'd0;
    funct7    = 7'd0;
    br_taken  = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    releaseReset();
  endtask

  // Runs one instruction from its first fetch cycle through its retire cycle and checks it
  task automatic applyStimulus(input string name, input int kind, input logic [2:0] f3, input logic [6:0] f7,
                               input logic br, input int fetchWaits, input int memWaits);
    int         fwLeft = fetchWaits;
    int         mwLeft = memWaits;
    int         cyc = 0;
    int         retireCyc = 0;
    int         irWeCnt = 0;
    int         rfWeCnt = 0;
    int         subCnt = 0;
    int         sraCnt = 0;
    int         holdErr = 0;
    int         weErr = 0;
    bit         done = 0;
    logic       rfAtRetire = 1'b0;
    logic [1:0] selAtRetire = 2'b00;
    logic       prevReq = 1'b0;
    logic       prevInstr = 1'b0;
    logic       prevWe = 1'b0;
    logic       prevReady = 1'b1;
    int         expLat;
    logic [1:0] expSel;
    int         expRf;
    int         expSub;
    int         expSra;
    logic       isStore;

    isStore = (kind == K_STORE);
    expLat  = (kind == K_BR) ? 3 : (kind == K_LOAD) ? 5 : 4;
    expLat += fetchWaits;
    if (kind == K_LOAD || kind == K_STORE) expLat += memWaits;
    expSel  = (kind == K_BR) ? (br ? 2'b01 : 2'b00) : (kind == K_JAL) ? 2'b10 : (kind == K_JALR) ? 2'b11 : 2'b00;
    expRf   = (kind == K_BR || kind == K_STORE) ? 0 : 1;
    expSub  = (kind == K_R && f3 == 3'b000 && f7 == 7'b0100000) ? 1 : 0;
    expSra  = ((kind == K_R || kind == K_I) && f3 == 3'b101 && f7[5]) ? 1 : 0;

    operation = opcodeOf(kind);
    funct3    = f3;
    funct7    = f7;
    br_taken  = br;

    while (!done && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
      if (mem_req && mem_instr) begin
        if (fwLeft > 0) begin
          mem_ready = 1'b0;
          fwLeft--;
        end else begin
          mem_ready = 1'b1;
        end
      end else if (mem_req) begin
        if (mwLeft > 0) begin
          mem_ready = 1'b0;
          mwLeft--;
        end else begin
          mem_ready = 1'b1;
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      if (prevReq && !prevReady && ({mem_req, mem_instr, mem_we} !== {prevReq, prevInstr, prevWe})) holdErr++;
      if (mem_req && !mem_instr && (mem_we !== isStore)) weErr++;
      if (ir_we) irWeCnt++;
      if (rf_we) rfWeCnt++;
      if (alu_sub) subCnt++;
      if (alu_sra) sraCnt++;
      prevReq   = mem_req;
      prevInstr = mem_instr;
      prevWe    = mem_we;
      prevReady = mem_ready;
      if (pc_we === 1'b1) begin
        done        = 1;
        retireCyc   = cyc;
        rfAtRetire  = rf_we;
        selAtRetire = pc_sel;
      end
    end

    checkOutput({name, " retired"}, done, 1);
    checkOutput({name, " latency"}, retireCyc, expLat);
    checkOutput({name, " pc_sel"}, selAtRetire, expSel);
    checkOutput({name, " rf_we at retire"}, rfAtRetire, expRf);
    checkOutput({name, " rf_we count"}, rfWeCnt, expRf);
    checkOutput({name, " ir_we count"}, irWeCnt, 1);
    checkOutput({name, " alu_sub count"}, subCnt, expSub);
    checkOutput({name, " alu_sra count"}, sraCnt, expSra);
    checkOutput({name, " request hold"}, holdErr, 0);
    checkOutput({name, " mem_we"}, weErr, 0);
    if (done) begin
      expRet = (expRet + 1) % RET_MOD;
      @(posedge clk);
      #1;
      checkOutput({name, " instret"}, instret, expRet);
    end
  endtask

  task automatic runRandom(input int count);
    for (int i = 0; i < count; i++) begin
      int         kind;
      logic [2:0] f3;
      logic [6:0] f7;
      kind = $urandom_range(0, 6);
      case ($urandom_range(0, 2))
        0:       f3 = 3'b000;
        1:       f3 = 3'b101;
        default: f3 = 3'($urandom_range(0, 7));
      endcase
      case ($urandom_range(0, 2))
        0:       f7 = 7'b0100000;
        1:       f7 = 7'b0000000;
        default: f7 = 7'($urandom_range(0, 127));
      endcase
      applyStimulus("rand", kind, f3, f7, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2));
    end
  endtask

  // Directed scenarios followed by randomized traffic, reset and halt cases
  initial begin
    bit found;
    int haltBad;

    resetDut();

    applyStimulus("add sub", K_R, 3'b000, 7'b0100000, 1'b0, 0, 0);
    applyStimulus("load waits", K_LOAD, 3'b010, 7'b0000000, 1'b0, 2, 1);
    applyStimulus("beq taken", K_BR, 3'b000, 7'b0000000, 1'b1, 0, 0);
    applyStimulus("beq not taken", K_BR, 3'b000, 7'b0000000, 1'b0, 0, 0);
    applyStimulus("jal", K_JAL, 3'b000, 7'b0000000, 1'b0, 0, 0);
    applyStimulus("jalr", K_JALR, 3'b000, 7'b0000000, 1'b0, 1, 0);
    applyStimulus("store waits", K_STORE, 3'b010, 7'b0000000, 1'b0, 1, 2);
    applyStimulus("srai", K_I, 3'b101, 7'b0100000, 1'b0, 0, 0);
    applyStimulus("srl", K_R, 3'b101, 7'b0000000, 1'b0, 0, 0);
    applyStimulus("add", K_R, 3'b000, 7'b0000000, 1'b0, 0, 0);

    runRandom(40);

    // Reset while a store is waiting in the memory phase
    operation = 7'b0100011;
    funct3    = 3'b010;
    funct7    = 7'd0;
    br_taken  = 1'b0;
    found     = 0;
    for (int c = 0; c < TIMEOUT && !found; c++) begin
      @(negedge clk);
      if (mem_req && !mem_instr) begin
        found     = 1;
        mem_ready = 1'b0;
      end else begin
        mem_ready = 1'b1;
      end
    end
    checkOutput("store reached MEM", found, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async rst mem_req", mem_req, 0);
    checkOutput("async rst mem_we", mem_we, 0);
    checkOutput("async rst pc_we", pc_we, 0);
    checkOutput("async rst rf_we", rf_we, 0);
    checkOutput("async rst instret", instret, 0);
    releaseReset();
    applyStimulus("after abort", K_R, 3'b000, 7'b0000000, 1'b0, 0, 0);

    // Counter wrap
    resetDut();
    runRandom(RET_MOD - 1);
    checkOutput("instret at max", instret, RET_MOD - 1);
    runRandom(1);
    checkOutput("instret wrapped", instret, 0);
    runRandom(2);

    // Illegal opcode halts until reset
    operation = 7'b0000000;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("halted during decode", halted, 0);
    haltBad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (halted !== 1'b1 || mem_req !== 1'b0 || pc_we !== 1'b0 || rf_we !== 1'b0 || ir_we !== 1'b0) haltBad++;
    end
    checkOutput("halt cycles", haltBad, 0);
    checkOutput("halted", halted, 1);
    checkOutput("instret held in halt", instret, expRet);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("halt cleared by reset", halted, 0);
    checkOutput("instret cleared by reset", instret, 0);
    releaseReset();
    applyStimulus("after halt", K_JAL, 3'b000, 7'b0000000, 1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
